regset_sb: RTL and testbench
============================

# regset_sb

Parametrised successor to the processor register set: multi-ported register file with configurable data width and depth, per-byte write enables, optional write-to-read bypass, optional hard-wired zero register, and a per-register busy scoreboard. Sits in the processor decode/writeback path. Decode reserves a destination register, and writeback clears the reservation when it writes the result. Decode reads operands together with their busy flags to detect hazards.

## Interface
Parameters:
- DATA_WIDTH, default 32: register width in bits; must be a multiple of 8.
- ADDR_WIDTH, default 5: address width; depth is 2^ADDR_WIDTH.
- ZERO_REG, default 1: 1 makes register 0 read as zero, ignore writes and never become busy.
- BYPASS, default 0: 1 forwards same-cycle write data to the read ports.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RES_N  in  1  asynchronous active-low reset; clears every register and every busy bit.
- D  in  DATA_WIDTH  write data.
- A_D  in  ADDR_WIDTH  write address.
- write_enable  in  1  write strobe.
- byte_enable  in  DATA_WIDTH/8  per-byte write mask; bit k covers D[8k+7:8k].
- A_Q0, A_Q1  in  ADDR_WIDTH  read addresses.
- Q0, Q1  out  DATA_WIDTH  read data, combinational.
- busy_Q0, busy_Q1  out  1  busy flag of the addressed register, combinational.
- reserve_enable  in  1  reservation request.
- A_R  in  ADDR_WIDTH  register to reserve.
- reserve_granted  out  1  combinational; the reservation presented this cycle will take effect.

## Operation
- **Write**
  - On a rising edge with write_enable=1 and RES_N=1, bytes of register A_D with byte_enable[k]=1 take D; other bytes are kept.
  - The same edge clears busy[A_D], even if byte_enable is all zero.
- **Read**
  - Q0 = reg[A_Q0] and busy_Q0 = busy[A_Q0]; Q1 and busy_Q1 likewise from A_Q1.
  - Both ports may address the same register.
- **Zero register** (ZERO_REG=1)
  - Reads of address 0 return 0 with busy 0.
  - Writes to address 0 are discarded.
  - reserve_granted=1 for A_R=0, but no bit is set.
- **Reserve**
  - reserve_granted = reserve_enable & (~busy[A_R] | (write_enable & A_D==A_R)).
  - On a rising edge with reserve_granted=1, busy[A_R] is set.
  - A request against a busy register that is not being written this cycle is refused: granted=0, no state change. The requester must retry.
- **Simultaneous write and reserve, same register**
  - Data is written and busy ends at 1; the reservation wins.
  - Different registers: both take effect independently.
- **Bypass** (BYPASS=1)
  - When write_enable=1 and A_Qn==A_D (and not register 0 under ZERO_REG), Qn is the merge of D (enabled bytes) and reg[A_D] (other bytes).
  - In that case busy_Qn=0, unless a reservation of the same register is also granted this cycle.
- **No bypass** (BYPASS=0): reads show the pre-edge contents and busy state.
- **Reset** (RES_N low, asynchronous, including mid-operation)
  - Immediately: all registers 0, all busy 0, so Q0=Q1=0 and busy_Q0=busy_Q1=0.
  - write_enable and reserve_enable are ignored while RES_N=0.
  - Operation resumes at the first rising edge after deassertion.

## Timing
- Write latency: 1 edge. Data is visible on a non-bypassed read immediately after the edge.
- Busy set and clear each take effect at the edge.
- Reads, busy flags and reserve_granted are purely combinational: zero latency.
- Throughput: one write, one reservation and two reads per cycle.
- Reset values of every output after reset: Q0=0, Q1=0, busy_Q0=0, busy_Q1=0.
- reserve_granted after reset equals reserve_enable, since all busy bits are clear.

## Test plan
- **Reset:** write 0xDEADBEEF to registers 1..31, pulse RES_N low mid-cycle -> every address reads 0 with busy 0 on both ports before the next edge.
- **Zero register and byte enables:**
  - Write 0xA5A5A5A5 to register 0 -> reads 0.
  - Write 0x11223344 with byte_enable=0xF to register 7, then 0xFFFFFFFF with byte_enable=0x5 -> register 7 reads 0x11FF33FF.
- **Scoreboard:**
  - Reserve register 9 -> busy_Q0=1 at A_Q0=9.
  - Second reserve of 9 -> reserve_granted=0.
  - Write 9 -> busy clears.
  - Write and reserve 9 in the same cycle -> data updated and busy_Q0=1.
- **Bypass:**
  - BYPASS=1: write 0xCAFEF00D to register 4 with A_Q1=4 -> Q1=0xCAFEF00D in the same cycle.
  - BYPASS=0: Q1 shows the old value until the edge.
- **Parameter sweep:** DATA_WIDTH=64, ADDR_WIDTH=3, ZERO_REG=0 with random data to all 8 registers -> each reads back exactly on both ports, and register 0 is writable.
- **Reset during reservation:** reserve register 12, assert RES_N low -> busy_Q0 at A_Q0=12 reads 0 immediately and remains 0 after release.

Source files
------------

// File: rtl/regset_sb.sv
// Multi-ported register file with per-byte write enables, optional bypass and
// zero register, and a per-register busy scoreboard for decode hazard detection.
module regset_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 0
) (
  input  logic                    CLK,
  input  logic                    RES_N,
  input  logic [DATA_WIDTH-1:0]   D,
  input  logic [ADDR_WIDTH-1:0]   A_D,
  input  logic                    write_enable,
  input  logic [DATA_WIDTH/8-1:0] byte_enable,
  input  logic [ADDR_WIDTH-1:0]   A_Q0,
  input  logic [ADDR_WIDTH-1:0]   A_Q1,
  output logic [DATA_WIDTH-1:0]   Q0,
  output logic [DATA_WIDTH-1:0]   Q1,
  output logic                    busy_Q0,
  output logic                    busy_Q1,
  input  logic                    reserve_enable,
  input  logic [ADDR_WIDTH-1:0]   A_R,
  output logic                    reserve_granted
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  write_ok;
  logic                  reserve_set;
  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic                  rd_busy [2];

  // Reservation handshake: reserve_enable is a request, reserve_granted means it
  // takes effect at this edge. There is no holding; a refused requester retries.
  assign reserve_granted = reserve_enable &
                           (~busy[A_R] | (write_enable & (A_D == A_R)));

  assign write_ok    = write_enable & ~((ZERO_REG != 0) && (A_D == '0));
  assign reserve_set = reserve_granted & ~((ZERO_REG != 0) && (A_R == '0));

  // Byte-merged value that register A_D takes at the edge.
  always_comb begin
    wr_data = regs[A_D];
    for (int k = 0; k < NB; k++) begin
      if (byte_enable[k]) wr_data[8*k +: 8] = D[8*k +: 8];
    end
  end

  // Reservation is applied after the clear so it wins on the same register.
  always_comb begin
    busy_nxt = busy;
    if (write_enable) busy_nxt[A_D] = 1'b0;
    if (reserve_set)  busy_nxt[A_R] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (write_ok) regs[A_D] <= wr_data;
      busy <= busy_nxt;
    end
  end

  assign rd_addr[0] = A_Q0;
  assign rd_addr[1] = A_Q1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
      if ((BYPASS != 0) && write_ok && (rd_addr[p] == A_D)) begin
        rd_data[p] = wr_data;
        rd_busy[p] = reserve_granted && (A_R == A_D);
      end
    end
  end

  assign Q0      = rd_data[0];
  assign Q1      = rd_data[1];
  assign busy_Q0 = rd_busy[0];
  assign busy_Q1 = rd_busy[1];

endmodule

// File: tb/tb_regset_sb.sv
// Directed bench for regset_sb: default instance, a bypass instance sharing its
// inputs, and a 64-bit / 8-entry instance without zero register.
module tb_regset_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Shared inputs for the 32-bit instances.
  logic [31:0] d;
  logic [4:0]  a_d, a_q0, a_q1, a_r;
  logic        we, re;
  logic [3:0]  be;
  logic [31:0] q0, q1, q0_b, q1_b;
  logic        bq0, bq1, rg, bq0_b, bq1_b, rg_b;

  // Wide instance.
  logic [63:0] wd, wq0, wq1;
  logic [2:0]  wa_d, wa_q0, wa_q1, wa_r;
  logic        wwe, wre, wbq0, wbq1, wrg;
  logic [7:0]  wbe;
  logic [63:0] wexp [8];

  int total = 0;
  int bad   = 0;

  regset_sb u_dut (
    .CLK(clk), .RES_N(rst_n), .D(d), .A_D(a_d), .write_enable(we),
    .byte_enable(be), .A_Q0(a_q0), .A_Q1(a_q1), .Q0(q0), .Q1(q1),
    .busy_Q0(bq0), .busy_Q1(bq1), .reserve_enable(re), .A_R(a_r),
    .reserve_granted(rg)
  );

  regset_sb #(.BYPASS(1)) u_byp (
    .CLK(clk), .RES_N(rst_n), .D(d), .A_D(a_d), .write_enable(we),
    .byte_enable(be), .A_Q0(a_q0), .A_Q1(a_q1), .Q0(q0_b), .Q1(q1_b),
    .busy_Q0(bq0_b), .busy_Q1(bq1_b), .reserve_enable(re), .A_R(a_r),
    .reserve_granted(rg_b)
  );

  regset_sb #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .ZERO_REG(0)) u_wide (
    .CLK(clk), .RES_N(rst_n), .D(wd), .A_D(wa_d), .write_enable(wwe),
    .byte_enable(wbe), .A_Q0(wa_q0), .A_Q1(wa_q1), .Q0(wq0), .Q1(wq1),
    .busy_Q0(wbq0), .busy_Q1(wbq1), .reserve_enable(wre), .A_R(wa_r),
    .reserve_granted(wrg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    d = '0; a_d = '0; a_q0 = '0; a_q1 = '0; a_r = 5'd3; we = 1'b0; re = 1'b1; be = 4'hF;
    wd = '0; wa_d = '0; wa_q0 = '0; wa_q1 = '0; wa_r = '0; wwe = 1'b0; wre = 1'b0; wbe = 8'hFF;

    // Reset state
    #12;
    a_q0 = 5'd3; a_q1 = 5'd17; #1;
    check("rst_q0", q0, 0);
    check("rst_q1", q1, 0);
    check("rst_bq0", bq0, 0);
    check("rst_bq1", bq1, 0);
    check("rst_grant_follows_req", rg, 1);
    re = 1'b0; #1;
    check("rst_grant_idle", rg, 0);
    rst_n = 1'b1;
    tick();

    // Fill 1..31 then reset mid-cycle
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; a_d = 5'(a); d = 32'hDEADBEEF; be = 4'hF;
      tick();
    end
    we = 1'b0; a_q0 = 5'd5; #1;
    check("fill_q0", q0, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    for (int a = 0; a < 32; a++) begin
      a_q0 = 5'(a); a_q1 = 5'(31 - a); #1;
      check("midrst_q0", q0, 0);
      check("midrst_q1", q1, 0);
    end
    check("midrst_bq0", bq0, 0);
    check("midrst_bq1", bq1, 0);
    rst_n = 1'b1;
    tick();

    // Zero register: write discarded, bypass does not apply
    we = 1'b1; a_d = 5'd0; d = 32'hA5A5A5A5; be = 4'hF; a_q0 = 5'd0; #1;
    check("zero_byp_q0", q0_b, 0);
    tick();
    we = 1'b0; #1;
    check("zero_q0", q0, 0);

    // Byte enables on register 7
    we = 1'b1; a_d = 5'd7; d = 32'h11223344; be = 4'hF;
    tick();
    d = 32'hFFFFFFFF; be = 4'h5;
    tick();
    we = 1'b0; be = 4'hF; a_q0 = 5'd7; a_q1 = 5'd7; #1;
    check("be_q0", q0, 32'h11FF33FF);
    check("be_q1", q1, 32'h11FF33FF);

    // Scoreboard: reserve 9, refused second reserve, write clears
    re = 1'b1; a_r = 5'd9; a_q0 = 5'd9; #1;
    check("res9_grant", rg, 1);
    tick();
    re = 1'b0; #1;
    check("res9_busy", bq0, 1);
    re = 1'b1; #1;
    check("res9_again_refused", rg, 0);
    we = 1'b1; a_d = 5'd10; d = 32'h0; #1;
    check("res9_other_write_refused", rg, 0);
    tick();
    re = 1'b0; we = 1'b0; #1;
    check("res9_still_busy", bq0, 1);
    we = 1'b1; a_d = 5'd9; d = 32'h12345678; be = 4'hF; #1;
    check("wr9_pre_edge_busy", bq0, 1);
    check("wr9_byp_busy", bq0_b, 0);
    check("wr9_byp_data", q0_b, 32'h12345678);
    tick();
    we = 1'b0; #1;
    check("wr9_busy_clear", bq0, 0);
    check("wr9_data", q0, 32'h12345678);

    // Write + reserve same register while busy: grant, reservation wins
    re = 1'b1; a_r = 5'd9;
    tick();
    we = 1'b1; a_d = 5'd9; d = 32'h9ABCDEF0; #1;
    check("wr_res9_grant", rg, 1);
    check("wr_res9_byp_busy", bq0_b, 1);
    check("wr_res9_byp_data", q0_b, 32'h9ABCDEF0);
    tick();
    we = 1'b0; re = 1'b0; #1;
    check("wr_res9_data", q0, 32'h9ABCDEF0);
    check("wr_res9_busy", bq0, 1);

    // Write 9 and reserve 10 in the same cycle
    we = 1'b1; a_d = 5'd9; d = 32'h0BADF00D; re = 1'b1; a_r = 5'd10; a_q1 = 5'd10;
    tick();
    we = 1'b0; re = 1'b0; #1;
    check("indep_busy9", bq0, 0);
    check("indep_busy10", bq1, 1);
    check("indep_data9", q0, 32'h0BADF00D);

    // Bypass vs no bypass on register 4
    we = 1'b1; a_d = 5'd4; d = 32'hCAFEF00D; be = 4'hF; a_q1 = 5'd4; #1;
    check("byp_q1", q1_b, 32'hCAFEF00D);
    check("nobyp_q1_old", q1, 0);
    tick();
    we = 1'b0; #1;
    check("nobyp_q1_new", q1, 32'hCAFEF00D);
    we = 1'b1; d = 32'h00001111; be = 4'h3; #1;
    check("byp_partial_q1", q1_b, 32'hCAFE1111);
    check("nobyp_partial_q1", q1, 32'hCAFEF00D);
    tick();
    we = 1'b0; be = 4'hF;

    // Wide instance: all 8 registers, including register 0
    for (int i = 0; i < 8; i++) wexp[i] = {$urandom(), $urandom()};
    for (int i = 0; i < 8; i++) begin
      wwe = 1'b1; wa_d = 3'(i); wd = wexp[i];
      tick();
    end
    wwe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wa_q0 = 3'(i); wa_q1 = 3'(7 - i); #1;
      check("wide_q0", wq0, wexp[i]);
      check("wide_q1", wq1, wexp[7 - i]);
    end
    wre = 1'b1; wa_r = 3'd0; wa_q0 = 3'd0;
    tick();
    wre = 1'b0; #1;
    check("wide_reg0_busy", wbq0, 1);

    // Reset during reservation of register 12
    re = 1'b1; a_r = 5'd12; a_q0 = 5'd12;
    tick();
    re = 1'b0; #1;
    check("res12_busy", bq0, 1);
    #1 rst_n = 1'b0; #1;
    check("res12_rst_busy", bq0, 0);
    re = 1'b1; we = 1'b1; a_d = 5'd12; d = 32'hFFFFFFFF;
    tick();
    check("res12_rst_ignored_busy", bq0, 0);
    check("res12_rst_ignored_data", q0, 0);
    re = 1'b0; we = 1'b0; rst_n = 1'b1;
    tick();
    check("res12_after_release", bq0, 0);
    check("wide_after_reset", wq0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
